// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing a single sqrt unit among N_REQ requesters.
// Sequences the unit's start/busy handshake and returns each result as a one-cycle strobe.
module sqrt_arbiter #(
  parameter int N_REQ         = 4,
  parameter int X_W           = 8,
  parameter int Y_W           = 4,
  parameter int START_TIMEOUT = 4
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [N_REQ-1:0]                           req_valid_i,
  input  logic [N_REQ*X_W-1:0]                       req_x_i,
  output logic [N_REQ-1:0]                           req_ready_o,
  output logic [N_REQ-1:0]                           rsp_valid_o,
  output logic [Y_W-1:0]                             rsp_y_o,
  output logic                                       rsp_err_o,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id_o,
  output logic                                       busy_o,
  output logic                                       sqrt_start_o,
  output logic [X_W-1:0]                             sqrt_x_o,
  input  logic                                       sqrt_busy_i,
  input  logic [Y_W-1:0]                             sqrt_y_i
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TO_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] scan_id;

  // Priority starts just after the most recently served requester.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      scan_id = ID_W'((int'(ptr_q) + i) % N_REQ);
      if (!win_found && req_valid_i[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    x_q <= x_d;
    y_q <= y_d;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    x_d          = x_q;
    y_d          = y_q;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    rsp_y_o      = '0;
    rsp_err_o    = 1'b0;
    sqrt_start_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          req_ready_o = N_REQ'(1) << win_id;
          id_d        = win_id;
          x_d         = req_x_i[int'(win_id)*X_W +: X_W];
          err_d       = 1'b0;
          state_d     = S_START;
        end
      end
      S_START: begin
        sqrt_start_o = 1'b1;
        cnt_d        = '0;
        state_d      = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        sqrt_start_o = 1'b1;
        if (sqrt_busy_i) begin
          state_d = S_RUN;
        end else if (cnt_q == TO_W'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!sqrt_busy_i) begin
          y_d     = sqrt_y_i;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rsp_valid_o = N_REQ'(1) << id_q;
        // A timed-out request never produced a result, so report zero.
        rsp_y_o     = err_q ? '0 : y_q;
        rsp_err_o   = err_q;
        ptr_d       = id_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o     = (state_q != S_IDLE);
  assign grant_id_o = busy_o ? id_q : '0;
  assign sqrt_x_o   = busy_o ? x_q : '0;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Randomized self-checking bench for sqrt_arbiter with a behavioural sqrt unit
// and a round-robin reference model.
module tb_sqrt_arbiter;
  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 4;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*XW-1:0] req_x;
  logic [N-1:0]  req_ready, rsp_valid;
  logic [YW-1:0] rsp_y;
  logic          rsp_err, busy, sqrt_start, sqrt_busy;
  logic [1:0]    grant;
  logic [XW-1:0] sqrt_x;
  logic [YW-1:0] sqrt_y;

  int checks = 0;
  int errors = 0;
  int exp_ptr;
  int unit_k;
  bit unit_dead;

  logic          ub = 1'b0;
  int            ucnt = 0;
  logic [YW-1:0] uy = '0;

  sqrt_arbiter #(.N_REQ(N), .X_W(XW), .Y_W(YW), .START_TIMEOUT(ST)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_x_i(req_x),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_y_o(rsp_y),
    .rsp_err_o(rsp_err), .grant_id_o(grant), .busy_o(busy),
    .sqrt_start_o(sqrt_start), .sqrt_x_o(sqrt_x), .sqrt_busy_i(sqrt_busy),
    .sqrt_y_i(sqrt_y)
  );

  always #5 clk = ~clk;

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Next requester to serve: first asserted bit after the last served id, wrapping.
  function automatic int pick(input logic [N-1:0] mask, input int last);
    for (int i = 1; i <= N; i++)
      if (mask[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  // Sqrt unit model: busy for unit_k cycles after seeing start, result ready when busy drops.
  always @(posedge clk) begin
    if (!rst) begin
      ub   <= 1'b0;
      ucnt <= 0;
    end else if (ub) begin
      if (ucnt <= 1) ub <= 1'b0;
      ucnt <= ucnt - 1;
    end else if (sqrt_start && !unit_dead) begin
      ub   <= 1'b1;
      ucnt <= unit_k;
      uy   <= YW'(isqrt(int'(sqrt_x)));
    end
  end
  assign sqrt_busy = ub;
  assign sqrt_y    = uy;

  task automatic wait_rsp(output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (|rsp_valid) begin
        got = 1'b1;
        cyc = c;
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    exp_ptr = N - 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = '0; req_x = '0; unit_dead = 1'b0; unit_k = 3;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid} !== 8'h00)
      $display("FAIL reset_handshake: got %b expected 00000000", {req_ready, rsp_valid});
    checks++;
    if ({busy, sqrt_start, rsp_err, rsp_y, grant, sqrt_x} !== 17'h0)
      $display("FAIL reset_outputs: got %h expected 0", {busy, sqrt_start, rsp_err, rsp_y, grant, sqrt_x});
    rst = 1'b1;
    exp_ptr = N - 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit got; int cyc;
    req_x[7:0] = 8'd25; unit_k = 3; req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b expected 0001", req_ready);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    checks++;
    if ({busy, sqrt_start, grant, sqrt_x} !== {1'b1, 1'b1, 2'd0, 8'd25})
      $display("FAIL single_start: got %h expected %h", {busy, sqrt_start, grant, sqrt_x}, {1'b1, 1'b1, 2'd0, 8'd25});
    wait_rsp(got, cyc);
    checks++;
    if (!got) begin $display("FAIL single_timeout: got no response expected one"); errors++; return; end
    // Response 3+k cycles after accept, one of which was consumed above.
    if ({rsp_valid, rsp_y, rsp_err} !== {4'b0001, 4'd5, 1'b0} || cyc != 5) begin
      $display("FAIL single_rsp: got v=%b y=%0d e=%b lat=%0d expected v=0001 y=5 e=0 lat=5", rsp_valid, rsp_y, rsp_err, cyc);
      errors++;
    end
    exp_ptr = 0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy} !== 5'b0) begin
      $display("FAIL single_pulse: got %b expected 00000", {rsp_valid, busy});
      errors++;
    end
  endtask

  task automatic test_rr();
    bit got; int cyc; int e;
    do_reset();
    req_x = $urandom;
    req_valid = 4'hF;
    for (int s = 0; s < 6; s++) begin
      e = pick(4'hF, exp_ptr);
      unit_k = $urandom_range(1, 4);
      wait_rsp(got, cyc);
      checks++;
      if (!got) begin $display("FAIL rr_timeout: got none expected id %0d", e); errors++; req_valid = '0; return; end
      checks++;
      if (rsp_valid !== 4'(1 << e) || grant !== 2'(e) || rsp_err !== 1'b0 ||
          int'(rsp_y) != isqrt(int'(req_x[e*XW +: XW]))) begin
        $display("FAIL rr_service%0d: got v=%b id=%0d y=%0d e=%b expected id %0d y=%0d", s, rsp_valid, grant, rsp_y, rsp_err, e, isqrt(int'(req_x[e*XW +: XW])));
        errors++;
      end
      exp_ptr = e;
      if (s == 5) req_valid = '0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0) begin $display("FAIL rr_pulse%0d: got %b expected 0000", s, rsp_valid); errors++; end
    end
  endtask

  task automatic test_fair();
    bit got; int cyc;
    int ord[3] = '{2, 0, 2};
    req_x = $urandom; unit_k = 2;
    req_valid = 4'b0100;
    @(posedge clk); #1 req_valid[0] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_rsp(got, cyc);
      checks++;
      if (!got) begin $display("FAIL fair_timeout: got none expected id %0d", ord[s]); errors++; req_valid = '0; return; end
      checks++;
      if (rsp_valid !== 4'(1 << ord[s]) || grant !== 2'(ord[s])) begin
        $display("FAIL fair_order%0d: got v=%b id=%0d expected id %0d", s, rsp_valid, grant, ord[s]);
        errors++;
      end
      req_valid[ord[s]] = (s == 0);
      @(negedge clk);
    end
    exp_ptr = 2;
  endtask

  task automatic test_timeout();
    int starts = 0; bit got = 1'b0;
    unit_dead = 1'b1;
    req_x[15:8] = $urandom; req_valid = 4'b0010;
    @(posedge clk); #1 req_valid = '0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (sqrt_start) starts++;
      if (|rsp_valid) got = 1'b1;
    end
    checks++;
    if (!got) begin $display("FAIL timeout_rsp: got none expected err response"); errors++; end
    checks++;
    if (starts != ST + 1) begin $display("FAIL timeout_start_len: got %0d expected %0d", starts, ST + 1); errors++; end
    checks++;
    if ({rsp_valid, rsp_err, rsp_y} !== {4'b0010, 1'b1, 4'd0}) begin
      $display("FAIL timeout_err: got v=%b e=%b y=%0d expected v=0010 e=1 y=0", rsp_valid, rsp_err, rsp_y);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin $display("FAIL timeout_idle: got busy=%b expected 0", busy); errors++; end
    unit_dead = 1'b0;
    exp_ptr = 1;
  endtask

  task automatic test_reset_midrun();
    bit got; int cyc; int seen = 0;
    unit_k = 10; req_x[7:0] = $urandom; req_valid = 4'b0001;
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, sqrt_start} !== 2'b10) begin $display("FAIL midrun_inrun: got %b expected 10", {busy, sqrt_start}); errors++; end
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    exp_ptr = N - 1;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, busy, sqrt_start, rsp_err, rsp_y, grant, sqrt_x} !== 25'h0) begin
      $display("FAIL midrun_reset: got %h expected 0", {req_ready, rsp_valid, busy, sqrt_start, rsp_err, rsp_y, grant, sqrt_x});
      errors++;
    end
    repeat (20) begin @(negedge clk); if (|rsp_valid) seen++; end
    checks++;
    if (seen != 0) begin $display("FAIL midrun_dropped: got %0d responses expected 0", seen); errors++; end
    unit_k = 2; req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin $display("FAIL midrun_ready: got %b expected 0010", req_ready); errors++; end
    @(posedge clk); #1 req_valid = 4'b1000;
    for (int s = 0; s < 2; s++) begin
      int e = (s == 0) ? pick(4'b1010, exp_ptr) : pick(4'b1000, exp_ptr);
      wait_rsp(got, cyc);
      checks++;
      if (!got || rsp_valid !== 4'(1 << e)) begin
        $display("FAIL midrun_order%0d: got v=%b expected id %0d", s, rsp_valid, e);
        errors++;
      end
      exp_ptr = e;
      if (s == 1) req_valid = '0;
    end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    bit got; int cyc;
    int xs[4] = '{0, 1, 13, 255};
    int ys[4] = '{0, 1, 3, 15};
    for (int i = 0; i < 4; i++) begin
      req_x[31:24] = 8'(xs[i]); unit_k = $urandom_range(1, 4); req_valid = 4'b1000;
      @(posedge clk); #1 req_valid = '0;
      wait_rsp(got, cyc);
      checks++;
      if (!got || rsp_valid !== 4'b1000 || int'(rsp_y) != ys[i] || rsp_err !== 1'b0) begin
        $display("FAIL sweep_x%0d: got v=%b y=%0d e=%b expected v=1000 y=%0d", xs[i], rsp_valid, rsp_y, rsp_err, ys[i]);
        errors++;
      end
      exp_ptr = 3;
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    bit got; int cyc; int e; logic [N-1:0] mask; logic [XW-1:0] xe;
    for (int it = 0; it < 20; it++) begin
      mask = N'($urandom_range(1, 15));
      req_x = $urandom;
      unit_k = $urandom_range(1, 5);
      e = pick(mask, exp_ptr);
      xe = req_x[e*XW +: XW];
      req_valid = mask;
      #1;
      checks++;
      if (req_ready !== 4'(1 << e)) begin $display("FAIL rand_ready%0d: got %b expected id %0d", it, req_ready, e); errors++; end
      @(posedge clk); #1;
      req_valid = '0;
      req_x = $urandom;
      wait_rsp(got, cyc);
      checks++;
      if (!got || rsp_valid !== 4'(1 << e) || int'(rsp_y) != isqrt(int'(xe)) || rsp_err !== 1'b0 || cyc != 3 + unit_k) begin
        $display("FAIL rand_rsp%0d: got v=%b y=%0d e=%b lat=%0d expected id %0d y=%0d lat=%0d", it, rsp_valid, rsp_y, rsp_err, cyc, e, isqrt(int'(xe)), 3 + unit_k);
        errors++;
      end
      exp_ptr = e;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_fair();
    test_timeout();
    test_reset_midrun();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
